cp_insert: RTL and testbench

CP_INSERT -- requirements
Module: cp_insert

---
 rtl/ofdm_pkg.sv | 16 +
 rtl/cp_buf_ram.sv | 20 ++
 rtl/cp_insert.sv | 173 +++++++++++++++++
 tb/tb_cp_insert.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared OFDM datapath constants and the cyclic-prefix reader state type.
package ofdm_pkg;
  localparam int SAMPLE_W   = 20;
  localparam int SYM_N      = 64;
  localparam int CP_LEN_DEF = 16;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CP   = 2'd1,
    RD_BODY = 2'd2
  } rd_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cp_buf_ram.sv
// Simple dual-port symbol buffer: one write port, one registered read port.
module cp_buf_ram #(
  parameter int DW = 40,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/cp_insert.sv
// Cyclic-prefix insertion with a ping-pong two-symbol buffer.
// Optional macro CP_INSERT_ERR_EN adds err: a mid-symbol in_sop restarts the symbol.
module cp_insert
  import ofdm_pkg::*;
#(
  parameter int W      = SAMPLE_W,
  parameter int N      = SYM_N,
  parameter int CP_LEN = CP_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] in_i,
  input  logic signed [W-1:0] in_q,
  input  logic                in_valid,
  input  logic                in_sop,
  output logic                in_ready,
  output logic signed [W-1:0] out_i,
  output logic signed [W-1:0] out_q,
  output logic                out_valid,
  output logic                out_sop
`ifdef CP_INSERT_ERR_EN
  ,
  output logic                err
`endif
);
  localparam int AW = idx_w(N);
  localparam logic [AW-1:0] IDX_LAST    = AW'(N - 1);
  localparam logic [AW-1:0] CP_FIRST    = AW'(N - CP_LEN);
  localparam logic [AW-1:0] CP_LAST_CNT = AW'(CP_LEN - 1);

  logic [1:0]    full, full_nx;
  logic          wr_bank, wr_active;
  logic [AW-1:0] wr_cnt, wr_idx;
  logic          accept, restart, start, wr_we, wr_done;

  rd_state_e     state, state_nx;
  logic          rd_bank, rd_bank_nx, rd_en, rel, sop0;
  logic [AW-1:0] rd_cnt, rd_cnt_nx, rd_idx;

  logic [2*W-1:0] rdata;
  logic [1:0]     vld_pipe, sop_pipe;

  // Writer: a bank is usable only while not full, so in_ready follows the addressed bank.
  assign in_ready = ~full[wr_bank];
  assign accept   = in_valid & in_ready;
`ifdef CP_INSERT_ERR_EN
  assign restart  = accept & wr_active & in_sop;
`else
  assign restart  = 1'b0;
`endif
  assign start    = accept & ((~wr_active & in_sop) | restart);
  assign wr_we    = start | (accept & wr_active);
  assign wr_idx   = start ? '0 : wr_cnt;
  assign wr_done  = accept & wr_active & ~restart & (wr_cnt == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_active <= 1'b0;
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
    end else if (start) begin
      wr_active <= 1'b1;
      wr_cnt    <= AW'(1);
    end else if (wr_done) begin
      wr_active <= 1'b0;
      wr_cnt    <= '0;
      wr_bank   <= ~wr_bank;
    end else if (accept & wr_active) begin
      wr_cnt    <= wr_cnt + AW'(1);
    end
  end

`ifdef CP_INSERT_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= restart;
  end
`endif

  // Release and completion touch different banks, so both apply in one cycle.
  always_comb begin
    full_nx = full;
    if (rel)     full_nx[rd_bank] = 1'b0;
    if (wr_done) full_nx[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) full <= '0;
    else     full <= full_nx;
  end

  // Reader: banks fill in strict alternation, so rd_bank is always the oldest.
  always_comb begin
    state_nx   = state;
    rd_bank_nx = rd_bank;
    rd_cnt_nx  = rd_cnt;
    rd_idx     = rd_cnt;
    rd_en      = 1'b0;
    rel        = 1'b0;
    sop0       = 1'b0;
    case (state)
      RD_IDLE: begin
        if (full[rd_bank]) begin
          state_nx  = RD_CP;
          rd_cnt_nx = '0;
        end
      end
      RD_CP: begin
        rd_en  = 1'b1;
        rd_idx = CP_FIRST + rd_cnt;
        sop0   = (rd_cnt == '0);
        if (rd_cnt == CP_LAST_CNT) begin
          state_nx  = RD_BODY;
          rd_cnt_nx = '0;
        end else begin
          rd_cnt_nx = rd_cnt + AW'(1);
        end
      end
      RD_BODY: begin
        rd_en = 1'b1;
        if (rd_cnt == IDX_LAST) begin
          rel        = 1'b1;
          rd_bank_nx = ~rd_bank;
          rd_cnt_nx  = '0;
          state_nx   = full[~rd_bank] ? RD_CP : RD_IDLE;
        end else begin
          rd_cnt_nx = rd_cnt + AW'(1);
        end
      end
      default: state_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      state   <= state_nx;
      rd_bank <= rd_bank_nx;
      rd_cnt  <= rd_cnt_nx;
    end
  end

  cp_buf_ram #(.DW(2*W), .AW(AW+1)) u_ram (
    .clk   (clk),
    .we    (wr_we),
    .waddr ({wr_bank, wr_idx}),
    .wdata ({in_i, in_q}),
    .re    (rd_en),
    .raddr ({rd_bank, rd_idx}),
    .rdata (rdata)
  );

  // Stage 0 aligns with RAM data; stage 1 is the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      sop_pipe <= '0;
      out_i    <= '0;
      out_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], rd_en};
      sop_pipe <= {sop_pipe[0], sop0};
      out_i    <= vld_pipe[0] ? rdata[2*W-1:W] : '0;
      out_q    <= vld_pipe[0] ? rdata[W-1:0]   : '0;
    end
  end

  assign out_valid = vld_pipe[1];
  assign out_sop   = sop_pipe[1];
endmodule

// File: tb/tb_cp_insert.sv
// Self-checking bench for cp_insert: vector table plus reset/latency sequences, queue-based model.
module tb_cp_insert;
  localparam int W  = 20;
  localparam int N  = 64;
  localparam int CP = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [W-1:0] in_i = '0, in_q = '0;
  logic                in_valid = 1'b0, in_sop = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] out_i, out_q;
  logic                out_valid, out_sop;
`ifdef CP_INSERT_ERR_EN
  logic                err;
`endif

  cp_insert #(.W(W), .N(N), .CP_LEN(CP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_i      (in_i),
    .in_q      (in_q),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_ready  (in_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid),
    .out_sop   (out_sop)
`ifdef CP_INSERT_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [W-1:0] i;
    logic signed [W-1:0] q;
    bit                  sop;
  } smp_t;

  typedef struct {
    int pre;       // samples without sop before the first symbol
    int mid;       // partial symbol length before the symbols, -1 for none
    int nsym;
    int gap;       // percent chance of an idle input cycle
    int kind;      // 0 ramp, 1 random, 2 extremes
    int exp_out;
    int exp_sop;
    int exp_run;   // minimum longest contiguous out_valid run
    bit exp_stall;
  } vec_t;

  int checks = 0;
  int errors = 0;

  smp_t exp_q[$];
  smp_t m_buf[$];
  smp_t s, e;
  bit   m_active = 1'b0;
  bit   err_pend = 1'b0;
  bit   rs;

  int ncyc = 0, last_acc_n = 0, first_sop_n = -1;
  int n_out = 0, n_sop = 0, run = 0, max_run = 0;
  bit ready_low = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic clr_stats();
    n_out = 0; n_sop = 0; run = 0; max_run = 0; ready_low = 1'b0; first_sop_n = -1;
  endtask

  // Reference model and scoreboard, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      exp_q.delete();
      m_buf.delete();
      m_active = 1'b0;
      err_pend = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_iq", (out_i != 0 || out_q != 0 || out_sop), 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      if (out_valid) begin
        n_out++;
        run++;
        if (run > max_run) max_run = run;
        if (out_sop) begin
          n_sop++;
          if (first_sop_n < 0) first_sop_n = ncyc;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_i", out_i, e.i);
          chk("out_q", out_q, e.q);
          chk("out_sop", out_sop, e.sop);
        end
      end else begin
        run = 0;
        chk("idle_outputs_zero", (out_i != 0 || out_q != 0 || out_sop), 0);
      end
      if (!in_ready) ready_low = 1'b1;
`ifdef CP_INSERT_ERR_EN
      chk("err", err, err_pend);
`endif
      err_pend = 1'b0;
      if (in_valid && in_ready) begin
        s.i = in_i; s.q = in_q; s.sop = 1'b0;
        if (!m_active) begin
          if (in_sop) begin
            m_buf = {s};
            m_active = 1'b1;
          end
        end else begin
          rs = 1'b0;
`ifdef CP_INSERT_ERR_EN
          rs = in_sop;
`endif
          if (rs) begin
            m_buf = {s};
            err_pend = 1'b1;
          end else begin
            m_buf.push_back(s);
            if (m_buf.size() == N) begin
              for (int j = N - CP; j < N; j++) begin
                e = m_buf[j];
                e.sop = (j == N - CP);
                exp_q.push_back(e);
              end
              for (int j = 0; j < N; j++) exp_q.push_back(m_buf[j]);
              m_active = 1'b0;
              last_acc_n = ncyc;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic signed [W-1:0] i, input logic signed [W-1:0] q,
                      input bit sop, input int gap);
    bit acc;
    acc = 1'b0;
    if (gap > 0 && $urandom_range(99) < gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_i = i; in_q = q; in_sop = sop; in_valid = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) chk("input_stall_timeout", 0, 1);
    in_valid = 1'b0;
    in_sop = 1'b0;
  endtask

  task automatic send_sym(input int kind, input int gap);
    logic signed [W-1:0] vi, vq;
    for (int k = 0; k < N; k++) begin
      case (kind)
        0: begin vi = W'(k); vq = -W'(k); end
        2: begin
          if (k % 2 == 0) begin vi = -20'sd524288; vq = 20'sd524287; end
          else begin vi = W'(k); vq = -W'(k); end
        end
        default: begin vi = W'($urandom); vq = W'($urandom); end
      endcase
      send(vi, vq, (k == 0), gap);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{pre:0, mid:-1, nsym:1, gap:0,  kind:0, exp_out:80,  exp_sop:1, exp_run:80,  exp_stall:1'b0};
    vt[1] = '{pre:0, mid:-1, nsym:3, gap:0,  kind:1, exp_out:240, exp_sop:3, exp_run:240, exp_stall:1'b1};
    vt[2] = '{pre:5, mid:-1, nsym:1, gap:30, kind:1, exp_out:80,  exp_sop:1, exp_run:80,  exp_stall:1'b0};
    vt[3] = '{pre:0, mid:-1, nsym:1, gap:0,  kind:2, exp_out:80,  exp_sop:1, exp_run:80,  exp_stall:1'b0};
    vt[4] = '{pre:0, mid:20, nsym:1, gap:0,  kind:1, exp_out:80,  exp_sop:1, exp_run:80,  exp_stall:1'b0};
    vt[5] = '{pre:0, mid:-1, nsym:2, gap:50, kind:1, exp_out:160, exp_sop:2, exp_run:80,  exp_stall:1'b0};

    // Reset state, during and after reset.
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_reset_outputs", (out_valid || out_sop || out_i != 0 || out_q != 0), 0);
    chk("post_reset_in_ready", in_ready, 1);

    // First output sop lands on the third edge after the accepting edge
    // (four falling-edge samples after the one that saw the acceptance).
    clr_stats();
    send_sym(0, 0);
    drain();
    chk("sop_latency", first_sop_n - last_acc_n, 4);
    chk("lat_n_out", n_out, 80);

    for (int v = 0; v < 6; v++) begin
      clr_stats();
      for (int p = 0; p < vt[v].pre; p++) send(W'($urandom), W'($urandom), 1'b0, vt[v].gap);
      if (vt[v].mid > 0)
        for (int p = 0; p < vt[v].mid; p++) send(W'(100 + p), W'(200 + p), (p == 0), 0);
      for (int k = 0; k < vt[v].nsym; k++) send_sym(vt[v].kind, vt[v].gap);
      drain();
      chk($sformatf("v%0d_n_out", v), n_out, vt[v].exp_out);
      chk($sformatf("v%0d_n_sop", v), n_sop, vt[v].exp_sop);
      chk($sformatf("v%0d_contig", v), (max_run >= vt[v].exp_run), 1);
      chk($sformatf("v%0d_stall", v), ready_low, vt[v].exp_stall);
    end

    // Reset with one symbol streaming out and the next half written.
    clr_stats();
    send_sym(1, 0);
    for (int p = 0; p < 30; p++) send(W'($urandom), W'($urandom), (p == 0), 0);
    chk("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_iq", (out_i != 0 || out_q != 0 || out_sop), 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clr_stats();
    for (int p = 0; p < 10; p++) send(W'($urandom), W'($urandom), 1'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("no_output_without_sop", n_out, 0);
    send_sym(0, 0);
    drain();
    chk("after_rst_n_out", n_out, 80);
    chk("after_rst_n_sop", n_sop, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
